// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared state encodings and select-width helper for the N-to-1 pipelined mux
package mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic int sel_width(input int num_in);
        return ($clog2(num_in) > 0) ? $clog2(num_in) : 1;
    endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// rtl/mux_nto1_comb.sv - combinational AND-OR N-to-1 word select; out-of-range sel yields zeros
module mux_nto1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] mdata,
    output logic [WIDTH-1:0]        word
);

    // One-hot AND-OR tree: codes with no matching input contribute nothing, giving zeros.
    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            word = word | (mdata[k*WIDTH +: WIDTH] & {WIDTH{sel == SEL_W'(k)}});
        end
    end

endmodule

// File: rtl/mux_nto1_pipe.sv
// rtl/mux_nto1_pipe.sv - N-to-1 select with registered valid/ready output and 2-entry skid; MUX_SEL_ERR_EN adds sticky sel_err
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] mdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out,
    output logic [SEL_W-1:0]        out_sel
`ifdef MUX_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    state_t             state;
    logic [WIDTH-1:0]   m_data;
    logic [SEL_W-1:0]   m_sel;
    logic [WIDTH-1:0]   s_data;
    logic [SEL_W-1:0]   s_sel;
    logic [WIDTH-1:0]   word;
    logic               accept;
    logic               emit;

    mux_nto1_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_comb (
        .sel   (sel),
        .mdata (mdata),
        .word  (word)
    );

    // Handshake flags decode only the state register, so no ready path runs through this stage.
    assign in_ready  = (state == ST_EMPTY) || (state == ST_ONE);
    assign out_valid = (state == ST_ONE) || (state == ST_TWO);
    assign out       = m_data;
    assign out_sel   = m_sel;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_EMPTY;
            m_data <= '0;
            m_sel  <= '0;
            s_data <= '0;
            s_sel  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_data <= word;
                        m_sel  <= sel;
                        state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        m_data <= word;
                        m_sel  <= sel;
                    end else if (accept) begin
                        s_data <= word;
                        s_sel  <= sel;
                        state  <= ST_TWO;
                    end else if (emit) begin
                        state  <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // The skid entry is always the younger beat, so it refills the main register.
                    if (emit) begin
                        m_data <= s_data;
                        m_sel  <= s_sel;
                        state  <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

`ifdef MUX_SEL_ERR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (accept && (int'(sel) >= NUM_IN)) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// tb/tb_mux_nto1_pipe.sv - self-checking bench for mux_nto1_pipe against a 2-deep FIFO reference model
module tb_mux_nto1_pipe;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_sel, a_out_sel;
    logic [95:0] a_mdata;
    logic [31:0] a_out;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0]  b_sel, b_out_sel;
    logic [39:0] b_mdata;
    logic [7:0]  b_out;

`ifdef MUX_SEL_ERR_EN
    logic a_sel_err, b_sel_err;
`endif

    mux_nto1_pipe #(.WIDTH(32), .NUM_IN(3)) u_a (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .sel       (a_sel),
        .mdata     (a_mdata),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out       (a_out),
        .out_sel   (a_out_sel)
`ifdef MUX_SEL_ERR_EN
        ,
        .sel_err   (a_sel_err)
`endif
    );

    mux_nto1_pipe #(.WIDTH(8), .NUM_IN(5)) u_b (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .sel       (b_sel),
        .mdata     (b_mdata),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out       (b_out),
        .out_sel   (b_out_sel)
`ifdef MUX_SEL_ERR_EN
        ,
        .sel_err   (b_sel_err)
`endif
    );

    function automatic logic [31:0] ref_a(input logic [95:0] md, input logic [1:0] s);
        if (s < 2'd3) return md[s*32 +: 32];
        return 32'h0;
    endfunction

    function automatic logic [7:0] ref_b(input logic [39:0] md, input logic [2:0] s);
        if (s < 3'd5) return md[s*8 +: 8];
        return 8'h0;
    endfunction

    task automatic test_reset();
        @(negedge clock);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%0b expected=0", a_out_valid); end
        checks++; if (a_out !== 32'h0) begin failures++; $display("FAIL reset_out actual=%h expected=0", a_out); end
        checks++; if (a_out_sel !== 2'd0) begin failures++; $display("FAIL reset_out_sel actual=%0d expected=0", a_out_sel); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%0b expected=1", a_in_ready); end
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_flags actual=%0b%0b expected=01", b_out_valid, b_in_ready); end
`ifdef MUX_SEL_ERR_EN
        checks++; if (a_sel_err !== 1'b0) begin failures++; $display("FAIL reset_sel_err actual=%0b expected=0", a_sel_err); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_select();
        @(negedge clock);
        a_mdata = {32'hC, 32'hB, 32'hA};
        a_sel = 2'd1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(negedge clock);
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL select_valid actual=%0b expected=1", a_out_valid); end
        checks++; if (a_out !== 32'hB) begin failures++; $display("FAIL select_out actual=%h expected=%h", a_out, 32'hB); end
        checks++; if (a_out_sel !== 2'd1) begin failures++; $display("FAIL select_out_sel actual=%0d expected=1", a_out_sel); end
        @(negedge clock);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL select_drained actual=%0b expected=0", a_out_valid); end
    endtask

    task automatic test_out_of_range();
        @(negedge clock);
        a_mdata = {$urandom, $urandom, $urandom} | 96'h1;
        a_sel = 2'd3; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(negedge clock);
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_out !== 32'h0) begin failures++; $display("FAIL oor_out actual=%0b/%h expected=1/0", a_out_valid, a_out); end
        checks++; if (a_out_sel !== 2'd3) begin failures++; $display("FAIL oor_out_sel actual=%0d expected=3", a_out_sel); end
`ifdef MUX_SEL_ERR_EN
        checks++; if (a_sel_err !== 1'b1) begin failures++; $display("FAIL oor_sel_err_set actual=%0b expected=1", a_sel_err); end
`endif
        @(negedge clock);
        a_sel = 2'd0; a_in_valid = 1'b1;
        @(negedge clock);
        a_in_valid = 1'b0;
        checks++; if (a_out !== a_mdata[31:0]) begin failures++; $display("FAIL oor_then_legal actual=%h expected=%h", a_out, a_mdata[31:0]); end
`ifdef MUX_SEL_ERR_EN
        checks++; if (a_sel_err !== 1'b1) begin failures++; $display("FAIL oor_sel_err_sticky actual=%0b expected=1", a_sel_err); end
`endif
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        logic [31:0] wa, wb, wc;
        wa = $urandom; wb = $urandom; wc = $urandom;
        @(negedge clock);
        a_mdata = {wc, wb, wa};
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 2'd0;
        @(negedge clock);
        checks++; if (a_out_valid !== 1'b1 || a_out !== wa || a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_one actual=%0b/%h/%0b expected=1/%h/1", a_out_valid, a_out, a_in_ready, wa); end
        a_sel = 2'd1;
        @(negedge clock);
        checks++; if (a_in_ready !== 1'b0 || a_out !== wa) begin failures++; $display("FAIL bp_two actual=%0b/%h expected=0/%h", a_in_ready, a_out, wa); end
        a_sel = 2'd2;
        @(negedge clock);
        checks++; if (a_in_ready !== 1'b0 || a_out !== wa || a_out_sel !== 2'd0) begin failures++; $display("FAIL bp_hold actual=%0b/%h/%0d expected=0/%h/0", a_in_ready, a_out, a_out_sel, wa); end
        a_out_ready = 1'b1;
        @(negedge clock);
        checks++; if (a_out !== wb || a_out_sel !== 2'd1 || a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_second actual=%h/%0d/%0b expected=%h/1/1", a_out, a_out_sel, a_in_ready, wb); end
        @(negedge clock);
        a_in_valid = 1'b0;
        checks++; if (a_out !== wc || a_out_sel !== 2'd2 || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_third actual=%h/%0d/%0b expected=%h/2/1", a_out, a_out_sel, a_out_valid, wc); end
        @(negedge clock);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained actual=%0b expected=0", a_out_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] qd[$];
        logic [1:0]  qs[$];
        int          emitted = 0;
        logic        acc, emt;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clock);
            checks++; if (a_out_valid !== (qd.size() > 0)) begin failures++; $display("FAIL stream_valid cyc=%0d actual=%0b expected=%0b", i, a_out_valid, qd.size() > 0); end
            if (qd.size() > 0) begin
                checks++; if (a_out !== qd[0] || a_out_sel !== qs[0]) begin failures++; $display("FAIL stream_data cyc=%0d actual=%h/%0d expected=%h/%0d", i, a_out, a_out_sel, qd[0], qs[0]); end
            end
            checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d actual=%0b expected=1", i, a_in_ready); end
            if (a_out_valid === 1'b1) emitted++;
            a_out_ready = 1'b1;
            a_in_valid = (i < 16);
            a_sel = 2'(i % 3);
            a_mdata = {$urandom, $urandom, $urandom};
            emt = (qd.size() > 0);
            acc = a_in_valid && (qd.size() < 2);
            if (emt) begin void'(qd.pop_front()); void'(qs.pop_front()); end
            if (acc) begin qd.push_back(ref_a(a_mdata, a_sel)); qs.push_back(a_sel); end
        end
        a_in_valid = 1'b0;
        checks++; if (emitted != 16) begin failures++; $display("FAIL stream_count actual=%0d expected=16", emitted); end
    endtask

    task automatic test_random();
        logic [7:0] qd[$];
        logic [2:0] qs[$];
        logic       prev_stall = 1'b0;
        logic [7:0] prev_out = '0;
        int         pushed = 0;
        int         popped = 0;
        logic       acc, emt;
        for (int i = 0; i < 404; i++) begin
            @(negedge clock);
            checks++; if (b_out_valid !== (qd.size() > 0) || b_in_ready !== (qd.size() < 2)) begin failures++; $display("FAIL rand_flags cyc=%0d actual=%0b%0b expected=%0b%0b", i, b_out_valid, b_in_ready, qd.size() > 0, qd.size() < 2); end
            if (qd.size() > 0) begin
                checks++; if (b_out !== qd[0] || b_out_sel !== qs[0]) begin failures++; $display("FAIL rand_data cyc=%0d actual=%h/%0d expected=%h/%0d", i, b_out, b_out_sel, qd[0], qs[0]); end
            end
            if (prev_stall) begin
                checks++; if (b_out !== prev_out) begin failures++; $display("FAIL rand_stall_stable cyc=%0d actual=%h expected=%h", i, b_out, prev_out); end
            end
            b_in_valid = (i < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
            b_out_ready = (i < 400) ? ($urandom_range(0, 2) != 0) : 1'b1;
            b_sel = 3'($urandom_range(0, 7));
            b_mdata = {8'($urandom), $urandom};
            emt = (qd.size() > 0) && b_out_ready;
            acc = b_in_valid && (qd.size() < 2);
            prev_stall = (qd.size() > 0) && !b_out_ready;
            prev_out = b_out;
            if (emt) begin void'(qd.pop_front()); void'(qs.pop_front()); popped++; end
            if (acc) begin qd.push_back(ref_b(b_mdata, b_sel)); qs.push_back(b_sel); pushed++; end
        end
        @(negedge clock);
        b_in_valid = 1'b0;
        checks++; if (b_out_valid !== 1'b0 || popped != pushed) begin failures++; $display("FAIL rand_drain actual=%0b/%0d expected=0/%0d", b_out_valid, popped, pushed); end
    endtask

    task automatic test_reset_mid_two();
        @(negedge clock);
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 2'd0;
        a_mdata = {$urandom, $urandom, $urandom} | 96'h1;
        @(negedge clock);
        a_sel = 2'd1;
        @(negedge clock);
        a_in_valid = 1'b0;
        checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin failures++; $display("FAIL midtwo_reach actual=%0b%0b expected=01", a_in_ready, a_out_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL midtwo_flags actual=%0b%0b expected=01", a_out_valid, a_in_ready); end
        checks++; if (a_out !== 32'h0 || a_out_sel !== 2'd0) begin failures++; $display("FAIL midtwo_out actual=%h/%0d expected=0/0", a_out, a_out_sel); end
`ifdef MUX_SEL_ERR_EN
        checks++; if (a_sel_err !== 1'b0) begin failures++; $display("FAIL midtwo_sel_err actual=%0b expected=0", a_sel_err); end
`endif
        @(negedge clock);
        reset = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL midtwo_no_ghost actual=%0b expected=0", a_out_valid); end
    endtask

    initial begin
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_sel = '0; a_mdata = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_sel = '0; b_mdata = '0;
        test_reset();
        test_select();
        test_out_of_range();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_mid_two();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
